// File: rtl/mac_tx_pkg.sv
// mac_tx_pkg
// Shared definitions for the MAC transmit scheduler:
//   - tx_state_t           : scheduler FSM state encoding
//   - *_DIBITS             : per-field dibit counts of one minimum-size frame
//   - FRAME_CYCLES_DEFAULT : cycles the scheduler waits after a start pulse
package mac_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } tx_state_t;

  // One dibit goes out per cycle, so each byte takes four cycles.
  // A minimum-size frame carries 14 header bytes, a 2-byte payload,
  // 44 pad bytes and a 4-byte FCS (64 bytes in total). The preamble,
  // SFD and inter-packet gap come on top of that.
  localparam int PREAMBLE_DIBITS = 28;
  localparam int SFD_DIBITS      = 4;
  localparam int HEADER_DIBITS   = 56;
  localparam int PAYLOAD_DIBITS  = 8;
  localparam int PAD_DIBITS      = 176;
  localparam int FCS_DIBITS      = 16;
  localparam int IPG_DIBITS      = 48;

  localparam int FRAME_DIBITS = PREAMBLE_DIBITS + SFD_DIBITS + HEADER_DIBITS +
                                PAYLOAD_DIBITS + PAD_DIBITS + FCS_DIBITS +
                                IPG_DIBITS;

  // A few spare cycles so the transmitter is idle again before the next
  // rising edge of mac_start.
  localparam int FRAME_MARGIN         = 4;
  localparam int FRAME_CYCLES_DEFAULT = FRAME_DIBITS + FRAME_MARGIN;

endpackage

// File: rtl/mac_tx_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts one position after
// last_grant and wraps from N_REQ-1 back to 0.
// Ports:
//   req        : request vector
//   last_grant : index of the most recent grant
//   en         : when low, no grant is produced
//   grant      : one-hot grant vector (all zero if nothing is granted)
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int LGW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LGW-1:0]   last_grant,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

  localparam logic [LGW:0] NR = (LGW + 1)'(N_REQ);

  logic [LGW:0]   sum;
  logic [LGW-1:0] idx;
  logic           found;

  // The extra bit of sum holds last_grant + k without overflow.
  // Wrapping to 0 needs at most one subtraction of N_REQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last_grant} + (LGW + 1)'(k);
      if (sum >= NR) begin
        sum = sum - NR;
      end
      idx = sum[LGW-1:0];
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_scheduler.sv
// mac_tx_scheduler
// Passes 16-bit payloads from N_REQ requesters to a MAC transmitter, one
// frame at a time. Requesters are served in round-robin order.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   enable       : allows new grants (a frame already started runs to the end)
//   req_valid    : per-requester payload-pending flags
//   req_data     : payloads; requester i is in bits [16*i+15:16*i]
//   req_ready    : one-hot accept strobe (combinational, IDLE state only)
//   mac_data     : latched payload, changes only on a handshake
//   mac_start    : one-cycle start pulse to the transmitter
//   busy         : high whenever the FSM is not in IDLE
//   frames_sent  : number of start pulses issued (wraps at 16 bits)
module mac_tx_scheduler
  import mac_tx_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [15:0]           mac_data,
  output logic                  mac_start,
  output logic                  busy,
  output logic [15:0]           frames_sent
);

  localparam int LGW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = $clog2(FRAME_CYCLES + 1);

  tx_state_t        state, state_next;
  logic [LGW-1:0]   last_grant;
  logic [LGW-1:0]   grant_idx;
  logic [N_REQ-1:0] grant;
  logic [15:0]      grant_data;
  logic [CW-1:0]    counter;
  logic             handshake;
  logic             arb_en;

  // rst_n is included here so that req_ready stays low while reset is held.
  assign arb_en = enable & rst_n & (state == ST_IDLE);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .LGW   (LGW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         (arb_en),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign handshake = |(grant & req_valid);
  assign busy      = (state != ST_IDLE);

  // Convert the one-hot grant into an index and select the payload
  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx  = LGW'(i);
        grant_data = req_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (handshake) state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (counter == '0) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // mac_start is registered from the handshake, so it is high exactly in
  // START. The counter is loaded in START, which makes WAIT last
  // FRAME_CYCLES cycles (counter values FRAME_CYCLES-1 down to 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_start   <= 1'b0;
      mac_data    <= '0;
      frames_sent <= '0;
      counter     <= '0;
      last_grant  <= LGW'(N_REQ - 1);
    end else begin
      mac_start <= handshake;
      if (handshake) begin
        mac_data    <= grant_data;
        last_grant  <= grant_idx;
        frames_sent <= frames_sent + 16'd1;
      end
      if (state == ST_START) begin
        counter <= CW'(FRAME_CYCLES - 1);
      end else if (state == ST_WAIT && counter != '0) begin
        counter <= counter - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// tb_mac_tx_scheduler
// Drives the scheduler with directed and random stimulus. Every cycle, all
// outputs are compared against a timeline model of the scheduler. The model
// tracks how many cycles have passed since the last accepted payload and
// selects the next requester with a plain modular search.
module tb_mac_tx_scheduler;

  localparam int N     = 2;
  localparam int FRAME = 8;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [N-1:0]  req_valid;
  logic [16*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [15:0]   mac_data;
  logic          mac_start;
  logic          busy;
  logic [15:0]   frames_sent;

  mac_tx_scheduler #(
    .N_REQ        (N),
    .FRAME_CYCLES (FRAME)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .mac_data    (mac_data),
    .mac_start   (mac_start),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // The model:
  //   m_age    : 0 when idle; 1 in the start cycle; 2..FRAME+1 while waiting
  //   m_last   : requester that was served most recently
  //   m_data   : payload most recently accepted
  //   m_frames : number of start pulses issued so far
  int           m_age;
  int           m_last;
  logic [15:0]  m_data;
  logic [15:0]  m_frames;
  logic [N-1:0] hs_vec;
  logic [N-1:0] obs_ready;
  int           cycle_no = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cycle_no, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [N-1:0] v,
                               input logic [16*N-1:0] d);
    enable    = en;
    req_valid = v;
    req_data  = d;
  endtask

  function automatic logic [N-1:0] modelPick(input logic [N-1:0] v, input int last);
    logic [N-1:0] r;
    r = '0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic modelReset();
    m_age    = 0;
    m_last   = N - 1;
    m_data   = 16'h0000;
    m_frames = 16'h0000;
  endtask

  // Check all outputs at the negedge, then advance the model at the posedge.
  task automatic runCycle();
    logic [N-1:0] exp_ready;
    @(negedge clk);
    exp_ready = (m_age == 0 && enable && rst_n) ? modelPick(req_valid, m_last) : '0;
    obs_ready = req_ready;
    checkOutput("req_ready",   32'(req_ready),   32'(exp_ready));
    checkOutput("busy",        32'(busy),        32'(m_age != 0));
    checkOutput("mac_start",   32'(mac_start),   32'(m_age == 1));
    checkOutput("mac_data",    32'(mac_data),    32'(m_data));
    checkOutput("frames_sent", 32'(frames_sent), 32'(m_frames));
    @(posedge clk);
    hs_vec = exp_ready;
    if (|exp_ready) begin
      for (int i = 0; i < N; i++) begin
        if (exp_ready[i]) begin
          m_last = i;
          m_data = req_data[16*i +: 16];
        end
      end
      m_frames = m_frames + 16'd1;
      m_age    = 1;
    end else if (m_age != 0) begin
      m_age++;
      if (m_age == FRAME + 2) m_age = 0;
    end
    cycle_no++;
    #1;
  endtask

  // Assert reset away from any clock edge, check that it takes effect
  // immediately, hold it for one edge, then release it.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_busy",        32'(busy),        32'(0));
    checkOutput("rst_mac_start",   32'(mac_start),   32'(0));
    checkOutput("rst_frames_sent", 32'(frames_sent), 32'(0));
    checkOutput("rst_mac_data",    32'(mac_data),    32'(0));
    checkOutput("rst_req_ready",   32'(req_ready),   32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int grants;
    int last_hs;
    logic [N-1:0]   nv;
    logic [16*N-1:0] nd;

    hs_vec    = '0;
    obs_ready = '0;
    rst_n     = 1'b0;
    applyStimulus(1'b1, 2'b11, 32'h2222_1111);
    modelReset();
    doReset();

    // Single request from requester 0
    applyStimulus(1'b1, 2'b01, 32'h0000_BEEF);
    runCycle();
    checkOutput("single_grant", 32'(obs_ready), 32'(2'b01));
    applyStimulus(1'b1, 2'b00, 32'h0000_0000);
    for (int c = 0; c < 10; c++) runCycle();
    checkOutput("single_idle", 32'(busy), 32'(0));

    // Round robin with both requesters valid all the time
    doReset();
    applyStimulus(1'b1, 2'b11, 32'h2222_1111);
    grants  = 0;
    last_hs = -1;
    for (int c = 0; c < 40; c++) begin
      runCycle();
      if (|obs_ready) begin
        checkOutput("rr_order", 32'(obs_ready), 32'(1 << (grants % 2)));
        if (last_hs >= 0) checkOutput("rr_spacing", 32'(c - last_hs), 32'(FRAME + 2));
        last_hs = c;
        grants++;
      end
    end
    checkOutput("rr_grants", 32'(grants), 32'(4));
    checkOutput("rr_frames", 32'(frames_sent), 32'(4));

    // With enable low there must be no grants
    for (int c = 0; c < 10; c++) runCycle();
    applyStimulus(1'b0, 2'b11, 32'h2222_1111);
    for (int c = 0; c < 20; c++) runCycle();
    // One grant, then enable drops during WAIT
    applyStimulus(1'b1, 2'b11, 32'h2222_1111);
    runCycle();
    applyStimulus(1'b0, 2'b11, 32'h2222_1111);
    for (int c = 0; c < 15; c++) runCycle();
    checkOutput("en_idle", 32'(busy), 32'(0));

    // Reset in the middle of WAIT
    applyStimulus(1'b1, 2'b01, 32'h0000_1234);
    runCycle();
    applyStimulus(1'b1, 2'b00, 32'h0000_1234);
    for (int c = 0; c < 4; c++) runCycle();
    applyStimulus(1'b1, 2'b10, 32'h5678_0000);
    doReset();
    runCycle();
    checkOutput("rst_first_grant", 32'(obs_ready), 32'(2'b10));
    applyStimulus(1'b0, 2'b00, 32'h0000_0000);
    for (int c = 0; c < 12; c++) runCycle();

    // frames_sent wraps from 0xFFFF to 0x0000
    force dut.frames_sent = 16'hFFFF;
    #1;
    release dut.frames_sent;
    m_frames = 16'hFFFF;
    applyStimulus(1'b1, 2'b01, 32'h0000_CAFE);
    runCycle();
    applyStimulus(1'b1, 2'b00, 32'h0000_0000);
    runCycle();
    checkOutput("wrap_frames", 32'(frames_sent), 32'(0));
    for (int c = 0; c < 10; c++) runCycle();

    // Random traffic: requesters hold valid until they are served, with
    // occasional drops and new payloads
    for (int c = 0; c < 1500; c++) begin
      nv = req_valid;
      nd = req_data;
      for (int i = 0; i < N; i++) begin
        if (hs_vec[i]) begin
          nv[i] = ($urandom_range(0, 1) == 0);
          nd[16*i +: 16] = 16'($urandom);
        end else if (!nv[i] && $urandom_range(0, 3) == 0) begin
          nv[i] = 1'b1;
          nd[16*i +: 16] = 16'($urandom);
        end else if (nv[i] && $urandom_range(0, 63) == 0) begin
          nv[i] = 1'b0;
        end
      end
      applyStimulus(($urandom_range(0, 15) != 0), nv, nd);
      runCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
